// File: rtl/mem_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mem_rr_arbiter
//
// Shares one port of a small synchronous-write / registered-read RAM among
// NREQ requesters. Each cycle one eligible requester is granted, its command
// is registered onto the RAM port, and for reads the RAM data is returned to
// that requester two cycles after its grant, tagged with its ID.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   req        per-requester request level, held until gnt is seen
//   req_wr     per-requester op: 1 = write, 0 = read
//   req_addr   flattened addresses, requester i at [i*AW +: AW]
//   req_wdata  flattened write data, requester i at [i*DW +: DW]
//   gnt        one-hot grant pulse (registered)
//   mem_we     RAM write enable
//   mem_addr   RAM address
//   mem_wdata  RAM write data
//   mem_rdata  RAM registered read data
//   rvalid     one-cycle read-return strobe
//   rid        requester ID of the read return
//   rdata      read-return data
//
// Build option:
//   MEM_ARB_FIXED_PRIO_EN  when defined, the lowest-index eligible requester
//                          wins and the round-robin pointer stays at 0. The
//                          one-cycle mask on the last winner still applies.
// ---------------------------------------------------------------------------
module mem_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 3,
  parameter int DW   = 4,
  parameter int IDW  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_wr,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    gnt,
  output logic               mem_we,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_wdata,
  input  logic [DW-1:0]      mem_rdata,
  output logic               rvalid,
  output logic [IDW-1:0]     rid,
  output logic [DW-1:0]      rdata
);

  logic [IDW-1:0]  ptr_r;
  logic [NREQ-1:0] mask_r;
  logic [NREQ-1:0] eligible_s;
  logic            found_s;
  logic [IDW-1:0]  win_s;
  logic [NREQ-1:0] win_onehot_s;
  logic            win_wr_s;
  logic [AW-1:0]   win_addr_s;
  logic [DW-1:0]   win_wdata_s;
  logic [IDW-1:0]  next_ptr_s;
  logic            rd_v1_r;
  logic            rd_v2_r;
  logic [IDW-1:0]  rd_id1_r;
  logic [IDW-1:0]  rd_id2_r;

  // Circular first-set search of the eligible requesters starting at ptr_r.
  always_comb begin
    eligible_s   = req & ~mask_r;
    found_s      = 1'b0;
    win_s        = '0;
    win_onehot_s = '0;
    win_wr_s     = 1'b0;
    win_addr_s   = '0;
    win_wdata_s  = '0;
    // Pass 0 scans indices >= ptr_r, pass 1 wraps round to those below it.
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found_s && eligible_s[i] && ((pass == 0) == (i >= int'(ptr_r)))) begin
          found_s         = 1'b1;
          win_s           = IDW'(i);
          win_onehot_s[i] = 1'b1;
          win_wr_s        = req_wr[i];
          win_addr_s      = req_addr[i*AW +: AW];
          win_wdata_s     = req_wdata[i*DW +: DW];
        end else begin
          // an earlier candidate already won; keep it
        end
      end
    end
  end

  // Next pointer value: one past the winner, wrapping at NREQ-1.
  always_comb begin
`ifdef MEM_ARB_FIXED_PRIO_EN
    next_ptr_s = '0;
`else
    if (int'(win_s) == NREQ - 1) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = win_s + IDW'(1);
    end
`endif
  end

  // Grant, RAM command registers, pointer and last-winner mask.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ptr_r     <= '0;
      mask_r    <= '0;
    end else if (found_s) begin
      gnt       <= win_onehot_s;
      mem_we    <= win_wr_s;
      mem_addr  <= win_addr_s;
      mem_wdata <= win_wdata_s;
      ptr_r     <= next_ptr_s;
      // The winner sits out the next cycle while it sees gnt and drops req.
      mask_r    <= win_onehot_s;
    end else begin
      gnt       <= '0;
      mem_we    <= 1'b0;
      mask_r    <= '0;
    end
  end

  // Read-return pipeline: stage 1 tracks the issued command, stage 2 the
  // cycle the RAM performs the read, then the return registers catch its data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_v1_r  <= 1'b0;
      rd_v2_r  <= 1'b0;
      rd_id1_r <= '0;
      rd_id2_r <= '0;
      rvalid   <= 1'b0;
      rid      <= '0;
      rdata    <= '0;
    end else begin
      rd_v1_r  <= found_s & ~win_wr_s;
      rd_id1_r <= win_s;
      rd_v2_r  <= rd_v1_r;
      rd_id2_r <= rd_id1_r;
      rvalid   <= rd_v2_r;
      if (rd_v2_r) begin
        rid   <= rd_id2_r;
        rdata <= mem_rdata;
      end else begin
        rid   <= rid;
        rdata <= rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_rr_arbiter
//
// Directed bench for mem_rr_arbiter with a behavioural 8x4 RAM (synchronous
// write, registered read). A cycle-by-cycle vector table drives the request
// inputs and lists the outputs expected after each clock edge; short
// hand-written sequences cover fixed priority and reset during a read.
// ---------------------------------------------------------------------------
module tb_mem_rr_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 3;
  localparam int DW   = 4;
  localparam int IDW  = 2;

  // requester i reads address i
  localparam logic [11:0] A_ID = {3'd3, 3'd2, 3'd1, 3'd0};

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  req_wr;
  logic [11:0] req_addr;
  logic [15:0] req_wdata;
  logic [3:0]  gnt;
  logic        mem_we;
  logic [2:0]  mem_addr;
  logic [3:0]  mem_wdata;
  logic [3:0]  mem_rdata;
  logic        rvalid;
  logic [1:0]  rid;
  logic [3:0]  rdata;

  logic        load;
  logic [3:0]  ram [8];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  wr;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic [3:0]  e_gnt;
    logic        e_we;
    logic [2:0]  e_addr;
    logic [3:0]  e_wdata;
    logic        e_rv;
    logic [1:0]  e_rid;
    logic [3:0]  e_rdata;
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  mem_rr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .rvalid    (rvalid),
    .rid       (rid),
    .rdata     (rdata)
  );

  // Behavioural RAM: preload while load is high, otherwise sync write and
  // registered read. Not affected by the arbiter reset.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 8; i++) begin
        ram[i] <= (i < 4) ? 4'(i + 1) : ((i == 4) ? 4'h9 : 4'h0);
      end
    end else begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  function automatic vec_t mk(input logic [3:0] r, input logic [3:0] w,
                              input logic [11:0] a, input logic [15:0] d,
                              input logic [3:0] g, input logic we,
                              input logic [2:0] ea, input logic [3:0] ed,
                              input logic rv, input logic [1:0] ri,
                              input logic [3:0] rd);
    vec_t v;
    v.req = r; v.wr = w; v.addr = a; v.wdata = d;
    v.e_gnt = g; v.e_we = we; v.e_addr = ea; v.e_wdata = ed;
    v.e_rv = rv; v.e_rid = ri; v.e_rdata = rd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] w,
                       input logic [11:0] a, input logic [15:0] d);
    req = r; req_wr = w; req_addr = a; req_wdata = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    load = 1'b1;
    drive(4'b0000, 4'b0000, 12'h000, 16'h0000);
    step();
    load = 1'b0;
    step();
    chk("reset gnt",       16'(gnt),       16'h0);
    chk("reset mem_we",    16'(mem_we),    16'h0);
    chk("reset mem_addr",  16'(mem_addr),  16'h0);
    chk("reset mem_wdata", 16'(mem_wdata), 16'h0);
    chk("reset rvalid",    16'(rvalid),    16'h0);
    chk("reset rid",       16'(rid),       16'h0);
    chk("reset rdata",     16'(rdata),     16'h0);
    rst = 1'b0;

`ifdef MEM_ARB_FIXED_PRIO_EN
    // Fixed priority: 1 before 3, the mask forces alternation.
    for (int k = 0; k < 4; k++) begin
      drive(4'b1010, 4'b0000, 12'h000, 16'h0000);
      step();
      chk($sformatf("fixed step%0d gnt", k), 16'(gnt), (k % 2 == 0) ? 16'h2 : 16'h8);
    end
`else
    // idle
    for (int k = 0; k < 5; k++)
      vq.push_back(mk(4'b0000, 4'b0000, 12'h000, 16'h0000, 4'b0000, 1'b0, 3'd0, 4'h0, 1'b0, 2'd0, 4'h0));
    // four reads, grants 0..3 back to back, returns two cycles later
    vq.push_back(mk(4'b1111, 4'b0000, A_ID, 16'h0000, 4'b0001, 1'b0, 3'd0, 4'h0, 1'b0, 2'd0, 4'h0));
    vq.push_back(mk(4'b1110, 4'b0000, A_ID, 16'h0000, 4'b0010, 1'b0, 3'd1, 4'h0, 1'b0, 2'd0, 4'h0));
    vq.push_back(mk(4'b1100, 4'b0000, A_ID, 16'h0000, 4'b0100, 1'b0, 3'd2, 4'h0, 1'b1, 2'd0, 4'h1));
    vq.push_back(mk(4'b1000, 4'b0000, A_ID, 16'h0000, 4'b1000, 1'b0, 3'd3, 4'h0, 1'b1, 2'd1, 4'h2));
    vq.push_back(mk(4'b0000, 4'b0000, 12'h000, 16'h0000, 4'b0000, 1'b0, 3'd3, 4'h0, 1'b1, 2'd2, 4'h3));
    vq.push_back(mk(4'b0000, 4'b0000, 12'h000, 16'h0000, 4'b0000, 1'b0, 3'd3, 4'h0, 1'b1, 2'd3, 4'h4));
    vq.push_back(mk(4'b0000, 4'b0000, 12'h000, 16'h0000, 4'b0000, 1'b0, 3'd3, 4'h0, 1'b0, 2'd0, 4'h0));
    // requester 1 writes A to addr 3, requester 2 reads it back
    vq.push_back(mk(4'b0010, 4'b0010, {3'd0, 3'd0, 3'd3, 3'd0}, 16'h00A0, 4'b0010, 1'b1, 3'd3, 4'hA, 1'b0, 2'd0, 4'h0));
    vq.push_back(mk(4'b0000, 4'b0000, 12'h000, 16'h0000, 4'b0000, 1'b0, 3'd3, 4'hA, 1'b0, 2'd0, 4'h0));
    vq.push_back(mk(4'b0100, 4'b0000, {3'd0, 3'd3, 3'd0, 3'd0}, 16'h0000, 4'b0100, 1'b0, 3'd3, 4'h0, 1'b0, 2'd0, 4'h0));
    vq.push_back(mk(4'b0000, 4'b0000, 12'h000, 16'h0000, 4'b0000, 1'b0, 3'd3, 4'h0, 1'b0, 2'd0, 4'h0));
    vq.push_back(mk(4'b0000, 4'b0000, 12'h000, 16'h0000, 4'b0000, 1'b0, 3'd3, 4'h0, 1'b1, 2'd2, 4'hA));
    // write addr 5 then an immediate read of addr 5 by another requester
    vq.push_back(mk(4'b0001, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd5}, 16'h0007, 4'b0001, 1'b1, 3'd5, 4'h7, 1'b0, 2'd0, 4'h0));
    vq.push_back(mk(4'b0010, 4'b0000, {3'd0, 3'd0, 3'd5, 3'd0}, 16'h0000, 4'b0010, 1'b0, 3'd5, 4'h0, 1'b0, 2'd0, 4'h0));
    vq.push_back(mk(4'b0000, 4'b0000, 12'h000, 16'h0000, 4'b0000, 1'b0, 3'd5, 4'h0, 1'b0, 2'd0, 4'h0));
    // ptr = 2: requesters 0 and 3 together, 3 wins then 0 (wrap)
    vq.push_back(mk(4'b1001, 4'b0000, {3'd1, 3'd0, 3'd0, 3'd0}, 16'h0000, 4'b1000, 1'b0, 3'd1, 4'h0, 1'b1, 2'd1, 4'h7));
    vq.push_back(mk(4'b0001, 4'b0000, {3'd1, 3'd0, 3'd0, 3'd0}, 16'h0000, 4'b0001, 1'b0, 3'd0, 4'h0, 1'b0, 2'd0, 4'h0));
    vq.push_back(mk(4'b0000, 4'b0000, 12'h000, 16'h0000, 4'b0000, 1'b0, 3'd0, 4'h0, 1'b1, 2'd3, 4'h2));
    vq.push_back(mk(4'b0000, 4'b0000, 12'h000, 16'h0000, 4'b0000, 1'b0, 3'd0, 4'h0, 1'b1, 2'd0, 4'h1));
    // ptr = 1: all request, requester 1 wins
    vq.push_back(mk(4'b1111, 4'b0000, A_ID, 16'h0000, 4'b0010, 1'b0, 3'd1, 4'h0, 1'b0, 2'd0, 4'h0));
    vq.push_back(mk(4'b0000, 4'b0000, 12'h000, 16'h0000, 4'b0000, 1'b0, 3'd1, 4'h0, 1'b0, 2'd0, 4'h0));
    vq.push_back(mk(4'b0000, 4'b0000, 12'h000, 16'h0000, 4'b0000, 1'b0, 3'd1, 4'h0, 1'b1, 2'd1, 4'h2));
    // requester 0 holds req six cycles: granted every other cycle
    for (int k = 0; k < 6; k++)
      vq.push_back(mk(4'b0001, 4'b0000, {3'd0, 3'd0, 3'd0, 3'd4}, 16'h0000,
                      (k % 2 == 0) ? 4'b0001 : 4'b0000, 1'b0, 3'd4, 4'h0,
                      (k == 2 || k == 4) ? 1'b1 : 1'b0, 2'd0, (k == 2 || k == 4) ? 4'h9 : 4'h0));
    vq.push_back(mk(4'b0000, 4'b0000, 12'h000, 16'h0000, 4'b0000, 1'b0, 3'd4, 4'h0, 1'b1, 2'd0, 4'h9));
    vq.push_back(mk(4'b0000, 4'b0000, 12'h000, 16'h0000, 4'b0000, 1'b0, 3'd4, 4'h0, 1'b0, 2'd0, 4'h0));

    foreach (vq[i]) begin
      drive(vq[i].req, vq[i].wr, vq[i].addr, vq[i].wdata);
      step();
      chk($sformatf("row%0d gnt", i),       16'(gnt),       16'(vq[i].e_gnt));
      chk($sformatf("row%0d mem_we", i),    16'(mem_we),    16'(vq[i].e_we));
      chk($sformatf("row%0d mem_addr", i),  16'(mem_addr),  16'(vq[i].e_addr));
      chk($sformatf("row%0d mem_wdata", i), 16'(mem_wdata), 16'(vq[i].e_wdata));
      chk($sformatf("row%0d rvalid", i),    16'(rvalid),    16'(vq[i].e_rv));
      if (vq[i].e_rv) begin
        chk($sformatf("row%0d rid", i),   16'(rid),   16'(vq[i].e_rid));
        chk($sformatf("row%0d rdata", i), 16'(rdata), 16'(vq[i].e_rdata));
      end
    end
`endif

    // Read issued by requester 0, then reset on the following edge.
    drive(4'b0001, 4'b0000, {3'd0, 3'd0, 3'd0, 3'd2}, 16'h0000);
    step();
    chk("rstseq gnt", 16'(gnt), 16'h1);
    chk("rstseq mem_addr", 16'(mem_addr), 16'h2);
    rst = 1'b1;
    drive(4'b0000, 4'b0000, 12'h000, 16'h0000);
    step();
    chk("rstseq gnt in rst",       16'(gnt),       16'h0);
    chk("rstseq mem_we in rst",    16'(mem_we),    16'h0);
    chk("rstseq mem_addr in rst",  16'(mem_addr),  16'h0);
    chk("rstseq mem_wdata in rst", 16'(mem_wdata), 16'h0);
    chk("rstseq rvalid in rst",    16'(rvalid),    16'h0);
    chk("rstseq rid in rst",       16'(rid),       16'h0);
    chk("rstseq rdata in rst",     16'(rdata),     16'h0);
    rst = 1'b0;
    // ptr and mask back at 0: requester 0 beats 3
    drive(4'b1001, 4'b0000, 12'h000, 16'h0000);
    step();
    chk("rstseq gnt after rst", 16'(gnt), 16'h1);
    chk("rstseq dropped return", 16'(rvalid), 16'h0);
    drive(4'b0000, 4'b0000, 12'h000, 16'h0000);
    step();
    chk("rstseq idle gnt", 16'(gnt), 16'h0);
    chk("rstseq idle rvalid", 16'(rvalid), 16'h0);
    step();
    chk("rstseq return rvalid", 16'(rvalid), 16'h1);
    chk("rstseq return rid", 16'(rid), 16'h0);
    chk("rstseq return rdata", 16'(rdata), 16'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
